// File: rtl/push_conditioner.sv
// Push-button conditioner: four-state debouncer with press/release strobes and a saturating press counter.
// Optional auto-repeat while held is enabled by defining PUSH_AUTOREPEAT_EN.
module push_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sypush,
    input  logic       en,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_param_check
        $error("push_conditioner: DEBOUNCE_CYCLES/REPEAT_CYCLES out of range 2..65535");
    end

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        press_d, release_d, held_d;
    logic [7:0]  count_d;

`ifdef PUSH_AUTOREPEAT_EN
    localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
    logic [15:0] rep_q, rep_d;

    // Repeat counter runs only while staying in HELD; any other path restarts it.
    always_comb begin
        rep_d = 16'd0;
        if (state_q == HELD && sypush) begin
            rep_d = (rep_q == REP_LAST) ? 16'd0 : rep_q + 16'd1;
        end else begin
            rep_d = 16'd0;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q <= 16'd0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    // State and debounce counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; cnt counts stable samples inside the two debounce states.
    always_comb begin
        state_d = state_q;
        cnt_d   = 16'd0;
        case (state_q)
            IDLE: begin
                state_d = sypush ? DB_PRESS : IDLE;
            end
            DB_PRESS: begin
                if (!sypush) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HELD: begin
                state_d = sypush ? HELD : DB_RELEASE;
            end
            DB_RELEASE: begin
                if (sypush) begin
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; strobes are gated by en but the FSM never is.
    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        if (state_q == DB_PRESS && sypush && cnt_q == DB_LAST) begin
            press_d = en;
`ifdef PUSH_AUTOREPEAT_EN
        end else if (state_q == HELD && sypush && rep_q == REP_LAST) begin
            press_d = en;
`endif
        end else if (state_q == DB_RELEASE && !sypush && cnt_q == DB_LAST) begin
            release_d = en;
        end else begin
            press_d   = 1'b0;
            release_d = 1'b0;
        end
        held_d = (state_d == HELD) || (state_d == DB_RELEASE);
        if (press_d && press_count != 8'hFF) begin
            count_d = press_count + 8'd1;
        end else begin
            count_d = press_count;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            press_pulse   <= press_d;
            release_pulse <= release_d;
            held          <= held_d;
            press_count   <= count_d;
        end
    end

endmodule

// File: tb/tb_push_conditioner.sv
// Self-checking bench for push_conditioner: a run-length reference model feeds a scoreboard queue per cycle.
module tb_push_conditioner;

    localparam int D = 16;
    localparam int R = 8;
`ifdef PUSH_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
    localparam int EXP_HOLD40 = 3;
    localparam int EXP_HOLD57 = 6;
`else
    localparam bit REP_ON = 1'b0;
    localparam int EXP_HOLD40 = 1;
    localparam int EXP_HOLD57 = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sypush;
    logic       en;
    logic       press_pulse;
    logic       release_pulse;
    logic       held;
    logic [7:0] press_count;

    push_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .sypush(sypush), .en(en),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .held(held), .press_count(press_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int press_seen = 0;
    int release_seen = 0;
    logic [10:0] exp_q[$];

    // reference model state
    bit m_lvl;
    int m_run;
    int m_rep;
    int m_cnt;
    bit m_p;
    bit m_r;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_lvl = 1'b0; m_run = 0; m_rep = 0; m_cnt = 0; m_p = 1'b0; m_r = 1'b0;
    endfunction

    function automatic void model_step(input bit p, input bit e);
        m_p = 1'b0;
        m_r = 1'b0;
        if (p != m_lvl) begin
            m_run++;
            m_rep = 0;
            if (m_run == D + 1) begin
                m_lvl = p;
                m_run = 0;
                if (e) begin
                    if (p) m_p = 1'b1;
                    else   m_r = 1'b1;
                end
            end
        end else begin
            if (REP_ON && m_lvl && m_run == 0) begin
                m_rep++;
                if (m_rep == R) begin
                    m_rep = 0;
                    if (e) m_p = 1'b1;
                end
            end else begin
                m_rep = 0;
            end
            m_run = 0;
        end
        if (m_p && m_cnt < 255) m_cnt++;
    endfunction

    task automatic drive(input logic p, input logic e);
        logic [10:0] want;
        sypush = p;
        en     = e;
        model_step(p, e);
        exp_q.push_back({m_p, m_r, m_lvl, 8'(m_cnt)});
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check_val("cycle", {21'd0, press_pulse, release_pulse, held, press_count}, {21'd0, want});
        check_val("excl", {31'd0, press_pulse & release_pulse}, 32'd0);
        if (press_pulse)   press_seen++;
        if (release_pulse) release_seen++;
    endtask

    task automatic hold(input logic p, input logic e, input int n);
        for (int i = 0; i < n; i++) drive(p, e);
    endtask

    initial begin
        int first;
        int cnt_before;
        rst = 1'b0; sypush = 1'b0; en = 1'b0;
        model_reset();
        #12;
        check_val("reset_outs", {21'd0, press_pulse, release_pulse, held, press_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // basic press/release with 40-cycle hold
        press_seen = 0; release_seen = 0;
        hold(1'b1, 1'b1, 40);
        check_val("hold40_press", press_seen, EXP_HOLD40);
        check_val("hold40_held", {31'd0, held}, 32'd1);
        hold(1'b0, 1'b1, 20);
        check_val("rel_pulses", release_seen, 32'd1);
        check_val("rel_held", {31'd0, held}, 32'd0);

        // glitches in IDLE and in HELD
        cnt_before = int'(press_count);
        press_seen = 0; release_seen = 0;
        hold(1'b1, 1'b1, 5);
        hold(1'b0, 1'b1, 5);
        check_val("idle_glitch_press", press_seen, 32'd0);
        check_val("idle_glitch_cnt", {24'd0, press_count}, 32'(cnt_before));
        hold(1'b1, 1'b1, 18);
        release_seen = 0;
        hold(1'b0, 1'b1, 5);
        hold(1'b1, 1'b1, 3);
        check_val("held_glitch_held", {31'd0, held}, 32'd1);
        check_val("held_glitch_rel", release_seen, 32'd0);
        hold(1'b0, 1'b1, 20);

        // en=0 press/release: held toggles, no strobes, count frozen
        cnt_before = int'(press_count);
        press_seen = 0; release_seen = 0;
        hold(1'b1, 1'b0, 20);
        check_val("en0_held", {31'd0, held}, 32'd1);
        hold(1'b0, 1'b0, 20);
        check_val("en0_pulses", press_seen + release_seen, 32'd0);
        check_val("en0_cnt", {24'd0, press_count}, 32'(cnt_before));
        hold(1'b1, 1'b1, 17);
        check_val("en1_cnt", {24'd0, press_count}, 32'(cnt_before + 1));
        hold(1'b0, 1'b1, 17);

        // async reset mid-debounce, then full requalification
        hold(1'b1, 1'b1, 11);
        #2 rst = 1'b0;
        #1;
        check_val("async_rst", {21'd0, press_pulse, release_pulse, held, press_count}, 32'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b1);
            if (press_pulse && first == 0) first = i;
        end
        check_val("post_rst_latency", first, 32'd17);
        hold(1'b0, 1'b1, 20);

        // saturation
        for (int i = 0; i < 300; i++) begin
            hold(1'b1, 1'b1, 17);
            hold(1'b0, 1'b1, 17);
        end
        check_val("sat_cnt", {24'd0, press_count}, 32'd255);

        // long hold: auto-repeat strobes when enabled
        press_seen = 0;
        hold(1'b1, 1'b1, 17 + 40);
        check_val("repeat_pulses", press_seen, EXP_HOLD57);
        check_val("repeat_sat", {24'd0, press_count}, 32'd255);
        hold(1'b0, 1'b1, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/push_conditioner.md
PUSH_CONDITIONER -- requirements
Module: push_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, which is the number of consecutive stable cycles needed to accept a level change (legal range 2..65535).
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 256, which is the auto-repeat period in cycles while held (legal range 2..65535; used only with PUSH_AUTOREPEAT_EN).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port sypush, input, 1 bit: push-button level, already synchronized to clk; 1 = pressed.
REQ-006 Port en, input, 1 bit: game-active qualifier for pulses and the press counter.
REQ-007 Port press_pulse, output, 1 bit: one-cycle strobe for each accepted press.
REQ-008 Port release_pulse, output, 1 bit: one-cycle strobe for each accepted release.
REQ-009 Port held, output, 1 bit: debounced button level.
REQ-010 Port press_count, output, 8 bits: saturating count of emitted press_pulse strobes.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE (stable released), DB_PRESS, HELD (stable pressed) and DB_RELEASE.
REQ-012 IDLE: on sypush=1 go to DB_PRESS with cnt=0; otherwise stay in IDLE.
REQ-013 DB_PRESS: with sypush=1 and cnt<DEBOUNCE_CYCLES-1, increment cnt; with sypush=1 and cnt==DEBOUNCE_CYCLES-1, go to HELD; with sypush=0, return to IDLE and clear cnt with no pulse.
REQ-014 HELD: on sypush=0 go to DB_RELEASE with cnt=0; otherwise stay in HELD.
REQ-015 DB_RELEASE: mirror of DB_PRESS with sypush=0 as the stable value; completion goes to IDLE; a glitch (sypush=1) returns to HELD with no pulse.
REQ-016 Latency: if edge 1 is the first edge sampling sypush=1 and sypush stays 1, press_pulse SHALL be high for exactly one cycle following edge DEBOUNCE_CYCLES+1; release SHALL follow the same rule.
REQ-017 held SHALL be 1 in HELD and DB_RELEASE and 0 in IDLE and DB_PRESS, with all outputs registered.
REQ-018 press_pulse and release_pulse SHALL assert only if en=1 at the producing edge; the FSM SHALL advance regardless of en.
REQ-019 press_count SHALL increment by 1 on every emitted press_pulse, including repeats, and saturate at 255 with no wrap.
REQ-020 A glitch shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no change to held or press_count.
REQ-021 press_pulse and release_pulse SHALL never be high in the same cycle.

Reset
REQ-022 While rst=0: state=IDLE, cnt=0, repeat counter=0, press_pulse=0, release_pulse=0, held=0, press_count=0, immediately and independent of clk.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL discard the pending event; after release, a still-pressed button SHALL requalify from IDLE with the full DEBOUNCE_CYCLES latency.

Configuration
REQ-024 Macro PUSH_AUTOREPEAT_EN defined: in HELD, a repeat counter SHALL count cycles from entry into HELD, emit a press_pulse (subject to en) every REPEAT_CYCLES cycles, and clear on leaving HELD or on a DB_RELEASE glitch back to HELD.
REQ-025 Macro PUSH_AUTOREPEAT_EN undefined: exactly one press_pulse per accepted press, and no repeat counter logic SHALL be present.

Verification
REQ-026 With DEBOUNCE_CYCLES=16 and en=1, sypush held 1 for 40 cycles -> one press_pulse after edge 17, held=1, press_count=1; then sypush=0 -> release_pulse after 17 edges, held=0.
REQ-027 In IDLE, a 5-cycle sypush=1 glitch -> no pulses, held=0, press_count=0; a 5-cycle 0-glitch in HELD -> held stays 1 and no release_pulse.
REQ-028 With en=0, a full press and release -> held toggles, no pulses, press_count=0; then en=1 and another press -> press_count=1.
REQ-029 rst pulsed low in DB_PRESS (cnt=10), sypush kept 1 -> outputs clear asynchronously; after rst=1, press_pulse appears after edge 17 counted from the first post-reset edge.
REQ-030 300 full presses with en=1 -> press_count=255 (saturated); with PUSH_AUTOREPEAT_EN and REPEAT_CYCLES=8, one 40-cycle hold past qualification -> 1+5 press_pulses.
